// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Execute-to-writeback stage. Buffers ALU results and flags in a
//             2-entry skid FIFO, owns the committed condition-code register,
//             and resolves branch conditions for the head entry.
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] result_i,
  input  logic             c_i,
  input  logic             z_i,
  input  logic             n_i,
  input  logic             v_i,
  input  logic [REGW-1:0]  rd_i,
  input  logic             wr_en_i,
  input  logic             set_flags_i,
  input  logic             is_branch_i,
  input  logic [3:0]       cond_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [REGW-1:0]  rd_o,
  output logic             wr_en_o,
  output logic             branch_o,
  output logic             taken_o,
  output logic [3:0]       ccr_o
);

  // Entry layout, MSB to LSB: {result, c, z, n, v, rd, wr_en, set_flags, is_branch, cond}
  localparam int EW = WIDTH + 4 + REGW + 3 + 4;
  localparam logic [1:0] c_full  = 2'd2;
  localparam logic [1:0] c_empty = 2'd0;

  logic [EW-1:0]    entry_q [0:1];
  logic [EW-1:0]    entry_d [0:1];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [3:0]       ccr_q, ccr_d;

  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    head;
  logic [3:0]       head_cond;
  logic             head_is_branch;
  logic             head_set_flags;
  logic             head_wr_en;
  logic [REGW-1:0]  head_rd;
  logic [3:0]       head_flags;
  logic [WIDTH-1:0] head_result;
  logic             push;
  logic             pop;
  logic [3:0]       eval_flags;
  logic             cond_true;

  assign in_entry = {result_i, c_i, z_i, n_i, v_i, rd_i, wr_en_i, set_flags_i, is_branch_i, cond_i};

  assign head           = entry_q[rd_ptr_q];
  assign head_cond      = head[3:0];
  assign head_is_branch = head[4];
  assign head_set_flags = head[5];
  assign head_wr_en     = head[6];
  assign head_rd        = head[7 +: REGW];
  assign head_flags     = head[7 + REGW +: 4];
  assign head_result    = head[11 + REGW +: WIDTH];

  // Ready depends only on registered occupancy, so no path from out_ready_i.
  assign in_ready_o  = (count_q != c_full);
  assign out_valid_o = (count_q != c_empty);

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // Next-state for FIFO storage, pointers, occupancy and the committed CCR.
  always_comb begin
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ccr_d      = ccr_q;
    if (flush_i) begin
      // Squashed entries never commit, so the CCR is left alone here.
      count_d  = c_empty;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = in_entry;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head_set_flags) begin
          ccr_d = head_flags;
        end
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      count_q    <= c_empty;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ccr_q      <= 4'b0000;
    end else begin
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ccr_q      <= ccr_d;
    end
  end

  // Branch condition: a flag-setting head is judged on its own flags.
  always_comb begin
    eval_flags = head_set_flags ? head_flags : ccr_q;
    cond_true  = 1'b0;
    case (head_cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = eval_flags[2];
      4'd2:  cond_true = ~eval_flags[2];
      4'd3:  cond_true = eval_flags[3];
      4'd4:  cond_true = ~eval_flags[3];
      4'd5:  cond_true = eval_flags[3] | eval_flags[2];
      4'd6:  cond_true = ~eval_flags[3] & ~eval_flags[2];
      4'd7:  cond_true = eval_flags[1] ^ eval_flags[0];
      4'd8:  cond_true = ~(eval_flags[1] ^ eval_flags[0]);
      4'd9:  cond_true = (eval_flags[1] ^ eval_flags[0]) | eval_flags[2];
      4'd10: cond_true = ~(eval_flags[1] ^ eval_flags[0]) & ~eval_flags[2];
      4'd11: cond_true = eval_flags[1];
      4'd12: cond_true = ~eval_flags[1];
      4'd13: cond_true = eval_flags[0];
      4'd14: cond_true = ~eval_flags[0];
      4'd15: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Head-derived outputs are forced low whenever the FIFO is empty.
  always_comb begin
    result_o = out_valid_o ? head_result : '0;
    rd_o     = out_valid_o ? head_rd : '0;
    wr_en_o  = head_wr_en & out_valid_o;
    branch_o = head_is_branch & out_valid_o;
    taken_o  = cond_true & head_is_branch & out_valid_o;
    ccr_o    = ccr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Self-checking bench for alu_result_stage against a queue-based
//             reference model of the buffered entries and committed flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] result_in, result_out;
  logic        c_in, z_in, n_in, v_in;
  logic [3:0]  rd_in, rd_out, cond_in, ccr_out;
  logic        wr_en_in, set_flags_in, is_branch_in;
  logic        wr_en_out, branch_out, taken_out;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  f;      // {C,Z,N,V}
    logic [3:0]  rd;
    logic        wr_en;
    logic        set_flags;
    logic        is_branch;
    logic [3:0]  cond;
  } ent_t;

  ent_t       q[$];
  logic [3:0] ccr_m = 4'b0000;

  alu_result_stage #(.WIDTH(32), .REGW(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result_in), .c_i(c_in), .z_i(z_in), .n_i(n_in), .v_i(v_in),
    .rd_i(rd_in), .wr_en_i(wr_en_in), .set_flags_i(set_flags_in),
    .is_branch_i(is_branch_in), .cond_i(cond_in), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result_out), .rd_o(rd_out), .wr_en_o(wr_en_out),
    .branch_o(branch_out), .taken_o(taken_out), .ccr_o(ccr_out)
  );

  always #5 clk = ~clk;

  // Inverse condition pairs: (1,2) (3,4) ... (13,14) and (0,15).
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic cf, zf, nf, vf, base, inv;
    int   k;
    cf = f[3]; zf = f[2]; nf = f[1]; vf = f[0];
    k  = (c == 4'd0 || c == 4'd15) ? 0 : (int'(c) + 1) / 2;
    case (k)
      0: base = 1'b1;
      1: base = zf;
      2: base = cf;
      3: base = cf | zf;
      4: base = (nf != vf);
      5: base = (nf != vf) | zf;
      6: base = nf;
      default: base = vf;
    endcase
    inv = (c == 4'd15) || (c != 4'd0 && c[0] == 1'b0);
    return inv ? ~base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    logic v;
    logic [3:0] ef;
    v = (q.size() != 0);
    if (v) h = q[0];
    else h = '{result: 32'd0, f: 4'd0, rd: 4'd0, wr_en: 1'b0, set_flags: 1'b0, is_branch: 1'b0, cond: 4'd0};
    ef = h.set_flags ? h.f : ccr_m;
    chk("in_ready",  {31'd0, in_ready},   {31'd0, (q.size() != 2)});
    chk("out_valid", {31'd0, out_valid},  {31'd0, v});
    chk("result",    result_out,          h.result);
    chk("rd",        {28'd0, rd_out},     {28'd0, h.rd});
    chk("wr_en",     {31'd0, wr_en_out},  {31'd0, h.wr_en & v});
    chk("branch",    {31'd0, branch_out}, {31'd0, h.is_branch & v});
    chk("taken",     {31'd0, taken_out},  {31'd0, h.is_branch & v & cond_ref(h.cond, ef)});
    chk("ccr",       {28'd0, ccr_out},    {28'd0, ccr_m});
  endtask

  // Advance one clock, updating the model with pre-edge handshake decisions.
  task automatic step();
    bit   pu, po;
    ent_t e;
    pu = in_valid && (q.size() != 2) && !flush;
    po = (q.size() != 0) && out_ready && !flush;
    e  = '{result: result_in, f: {c_in, z_in, n_in, v_in}, rd: rd_in, wr_en: wr_en_in,
           set_flags: set_flags_in, is_branch: is_branch_in, cond: cond_in};
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (po) begin
        if (q[0].set_flags) ccr_m = q[0].f;
        void'(q.pop_front());
      end
      if (pu) q.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic set_in(input logic [31:0] r, input logic [3:0] f, input logic [3:0] rd,
                        input logic we, input logic sf, input logic br, input logic [3:0] c);
    result_in = r; {c_in, z_in, n_in, v_in} = f; rd_in = rd;
    wr_en_in = we; set_flags_in = sf; is_branch_in = br; cond_in = c;
  endtask

  // Hold an entry upstream until accepted, bounded to a fixed cycle budget.
  task automatic send(input logic [31:0] r, input logic [3:0] f, input logic [3:0] rd,
                      input logic we, input logic sf, input logic br, input logic [3:0] c);
    bit acc;
    set_in(r, f, rd, we, sf, br, c);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = (q.size() != 2);
      step();
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] ccr_before;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_all();

    // 1: single entry through an idle stage
    out_ready = 1'b1;
    send(32'h0000_0005, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t1_result", result_out, 32'd5);
    chk("t1_rd", {28'd0, rd_out}, 32'd3);
    step();
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // 2: backpressure with three back-to-back entries
    out_ready = 1'b0;
    set_in(32'hAAAA_0001, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0); in_valid = 1'b1; step();
    set_in(32'hBBBB_0002, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0); step();
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    set_in(32'hCCCC_0003, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0); step(); step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();

    // 3: flag commit followed by EQ / NE branches
    send(32'h0, 4'b0100, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    send(32'h100, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    chk("t3_ccr", {28'd0, ccr_out}, 32'h4);
    chk("t3_eq_taken", {31'd0, taken_out}, 32'd1);
    send(32'h104, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2);
    chk("t3_ne_taken", {31'd0, taken_out}, 32'd0);

    // 4: own flags take priority over the CCR
    send(32'h0, 4'b0000, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0);
    send(32'h200, 4'b0010, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
    chk("t4_ccr_zero", {28'd0, ccr_out}, 32'd0);
    chk("t4_lt_taken", {31'd0, taken_out}, 32'd1);
    send(32'h204, 4'b0010, 4'd0, 1'b0, 1'b1, 1'b1, 4'd8);
    chk("t4_ge_taken", {31'd0, taken_out}, 32'd0);
    step();

    // 5: flush with two buffered flag-setting entries and a live input
    out_ready = 1'b0;
    send(32'h11, 4'b0100, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    send(32'h22, 4'b0100, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    ccr_before = ccr_m;
    set_in(32'h33, 4'b0100, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_ccr", {28'd0, ccr_out}, {28'd0, ccr_before});

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      set_in($urandom, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom));
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // 6: asynchronous reset while full
    out_ready = 1'b1;
    send(32'h0, 4'b1111, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    out_ready = 1'b0;
    send(32'h44, 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0);
    send(32'h55, 4'b0000, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t6_pre_ccr", {28'd0, ccr_out}, 32'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_ccr", {28'd0, ccr_out}, 32'd0);
    chk("t6_async_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    ccr_m = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();

    // Sweep every condition code against every flag combination
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_in(32'(c * 16 + f), 4'(f), 4'(c), 1'b0, 1'b1, 1'b1, 4'(c));
        step();
        chk("sweep_taken", {31'd0, taken_out}, {31'd0, cond_ref(4'(c), 4'(f))});
      end
    end
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
